// File: rtl/ram_arb_mux.sv
// rtl/ram_arb_mux.sv - N-port single-RAM arbiter/mux with per-port held read data
// Define RAM_ARB_RR_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module ram_arb_mux #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS-1:0]             port_req_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr_i,
   input  logic [NUM_PORTS-1:0]             port_we_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_be_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata_i,
   output logic [NUM_PORTS-1:0]             port_gnt_o,
   output logic [NUM_PORTS-1:0]             port_rvalid_o,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  port_rdata_o,
   output logic                             ram_en_o,
   output logic [ADDR_WIDTH-1:0]            ram_addr_o,
   output logic                             ram_we_o,
   output logic [DATA_WIDTH/8-1:0]          ram_be_o,
   output logic [DATA_WIDTH-1:0]            ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]            ram_rdata_i
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic                  gnt_any;
   logic [IDX_W-1:0]      gnt_idx;
   logic                  resp_valid_q;
   logic                  resp_read_q;
   logic [IDX_W-1:0]      resp_idx_q;
   logic [DATA_WIDTH-1:0] hold_q [NUM_PORTS];

`ifdef RAM_ARB_RR_EN
   logic [IDX_W-1:0] last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= IDX_W'(NUM_PORTS - 1);
      end else if (gnt_any) begin
         last_q <= gnt_idx;
      end
   end

   // Search starts just after the last winner, wrapping without a modulo.
   always_comb begin
      int cand;
      cand    = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = int'(last_q) + i;
         if (cand >= NUM_PORTS) begin
            cand = cand - NUM_PORTS;
         end
         if (!gnt_any && port_req_i[IDX_W'(cand)]) begin
            gnt_any = 1'b1;
            gnt_idx = IDX_W'(cand);
         end
      end
   end
`else
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (port_req_i[IDX_W'(i)]) begin
            gnt_any = 1'b1;
            gnt_idx = IDX_W'(i);
         end
      end
   end
`endif

   always_comb begin
      port_gnt_o  = '0;
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_wdata_o = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (gnt_any && gnt_idx == IDX_W'(k)) begin
            port_gnt_o[k] = 1'b1;
            ram_addr_o    = port_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            ram_we_o      = port_we_i[k];
            ram_be_o      = port_be_i[k*BE_W +: BE_W];
            ram_wdata_o   = port_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign ram_en_o = gnt_any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_q <= 1'b0;
         resp_read_q  <= 1'b0;
         resp_idx_q   <= '0;
      end else begin
         resp_valid_q <= gnt_any;
         resp_read_q  <= gnt_any & ~ram_we_o;
         resp_idx_q   <= gnt_idx;
      end
   end

   // Only read responses update the hold register of the owning port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            hold_q[k] <= '0;
         end
      end else if (resp_valid_q && resp_read_q) begin
         hold_q[resp_idx_q] <= ram_rdata_i;
      end
   end

   always_comb begin
      port_rvalid_o = '0;
      port_rdata_o  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         port_rvalid_o[k] = resp_valid_q && (resp_idx_q == IDX_W'(k));
         if (port_rvalid_o[k] && resp_read_q) begin
            port_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = ram_rdata_i;
         end else begin
            port_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = hold_q[k];
         end
      end
   end

endmodule

// File: tb/tb_ram_arb_mux.sv
// tb/tb_ram_arb_mux.sv - directed table-driven bench for ram_arb_mux (4 ports)
module tb_ram_arb_mux;

   localparam int NP = 4;
   localparam int AW = 15;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NP-1:0]   req;
   logic [NP*AW-1:0] addr;
   logic [NP-1:0]   we;
   logic [NP*BW-1:0] be;
   logic [NP*DW-1:0] wdata;
   logic [NP-1:0]   gnt;
   logic [NP-1:0]   rvalid;
   logic [NP*DW-1:0] rdata;
   logic            ram_en;
   logic [AW-1:0]   ram_addr;
   logic            ram_we;
   logic [BW-1:0]   ram_be;
   logic [DW-1:0]   ram_wdata;
   logic [DW-1:0]   ram_rdata;
   logic            preload;

   logic [DW-1:0]   mem [256];

   int checks = 0;
   int errors = 0;

   ram_arb_mux #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .port_req_i   (req),
      .port_addr_i  (addr),
      .port_we_i    (we),
      .port_be_i    (be),
      .port_wdata_i (wdata),
      .port_gnt_o   (gnt),
      .port_rvalid_o(rvalid),
      .port_rdata_o (rdata),
      .ram_en_o     (ram_en),
      .ram_addr_o   (ram_addr),
      .ram_we_o     (ram_we),
      .ram_be_o     (ram_be),
      .ram_wdata_o  (ram_wdata),
      .ram_rdata_i  (ram_rdata)
   );

   always #5 clk = ~clk;

   // One-cycle-latency RAM; non-read cycles drive a junk word so hold behaviour is visible.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem[8'h10] <= 32'hDEAD_BEEF;
         ram_rdata  <= 32'hBAD0_BAD0;
      end else begin
         if (ram_en && ram_we) begin
            for (int b = 0; b < BW; b++) begin
               if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
         end
         if (ram_en && !ram_we) ram_rdata <= mem[ram_addr[7:0]];
         else                   ram_rdata <= 32'hBAD0_BAD0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rd(input int k);
      return rdata[k*DW +: DW];
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [NP-1:0] req;
      logic [NP-1:0] gnt_fp;
      logic [NP-1:0] gnt_rr;
   } vec_t;

   vec_t vecs [13];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [NP-1:0] exp_gnt;
      logic [NP-1:0] prev_gnt;
      logic [AW-1:0] exp_addr;

      vecs[0]  = '{4'b1111, 4'b0001, 4'b0001};
      vecs[1]  = '{4'b1111, 4'b0001, 4'b0010};
      vecs[2]  = '{4'b1111, 4'b0001, 4'b0100};
      vecs[3]  = '{4'b1111, 4'b0001, 4'b1000};
      vecs[4]  = '{4'b1111, 4'b0001, 4'b0001};
      vecs[5]  = '{4'b0101, 4'b0001, 4'b0100};
      vecs[6]  = '{4'b0101, 4'b0001, 4'b0001};
      vecs[7]  = '{4'b0100, 4'b0100, 4'b0100};
      vecs[8]  = '{4'b0000, 4'b0000, 4'b0000};
      vecs[9]  = '{4'b1010, 4'b0010, 4'b1000};
      vecs[10] = '{4'b1010, 4'b0010, 4'b0010};
      vecs[11] = '{4'b1001, 4'b0001, 4'b1000};
      vecs[12] = '{4'b0000, 4'b0000, 4'b0000};

      rst_n = 1'b0; preload = 1'b1;
      req = '0; we = '0; addr = '0; be = '0; wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_rvalid", 64'(rvalid), 64'h0);
      chk("rst_rdata", 64'(|rdata), 64'h0);
      chk("rst_ram_en", 64'(ram_en), 64'h0);

      next_cycle();
      preload = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      chk("idle_gnt", 64'(gnt), 64'h0);
      chk("idle_rvalid", 64'(rvalid), 64'h0);
      chk("idle_rdata", 64'(|rdata), 64'h0);
      chk("idle_ram_en", 64'(ram_en), 64'h0);

      // Arbitration table: port k reads address 0x100+k.
      prev_gnt = '0;
      for (int r = 0; r < 13; r++) begin
         next_cycle();
         req  = vecs[r].req;
         we   = '0;
         addr = {15'h103, 15'h102, 15'h101, 15'h100};
`ifdef RAM_ARB_RR_EN
         exp_gnt = vecs[r].gnt_rr;
`else
         exp_gnt = vecs[r].gnt_fp;
`endif
         exp_addr = '0;
         for (int k = 0; k < NP; k++) if (exp_gnt[k]) exp_addr = AW'(15'h100 + k);
         @(negedge clk);
         chk($sformatf("tbl%0d_gnt", r), 64'(gnt), 64'(exp_gnt));
         chk($sformatf("tbl%0d_rvalid", r), 64'(rvalid), 64'(prev_gnt));
         chk($sformatf("tbl%0d_ram_en", r), 64'(ram_en), 64'(|exp_gnt));
         chk($sformatf("tbl%0d_ram_addr", r), 64'(ram_addr), 64'(exp_addr));
         prev_gnt = exp_gnt;
      end

      // Single read by port 1 with held data afterwards.
      next_cycle();
      req = 4'b0010; addr = '0; addr[1*AW +: AW] = 15'h010;
      @(negedge clk);
      chk("rd_gnt", 64'(gnt), 64'h2);
      chk("rd_ram_addr", 64'(ram_addr), 64'h10);
      chk("rd_ram_we", 64'(ram_we), 64'h0);
      next_cycle();
      req = '0;
      @(negedge clk);
      chk("rd_rvalid", 64'(rvalid), 64'h2);
      chk("rd_rdata", 64'(rd(1)), 64'hDEAD_BEEF);
      next_cycle();
      @(negedge clk);
      chk("rd_rvalid_off", 64'(rvalid), 64'h0);
      chk("rd_hold", 64'(rd(1)), 64'hDEAD_BEEF);

      // Port 0 write then pipelined read of the same word.
      next_cycle();
      req = 4'b0001; we = 4'b0001; addr = '0; addr[0 +: AW] = 15'h004;
      be = '0; be[0 +: BW] = 4'hF; wdata = '0; wdata[0 +: DW] = 32'h1234_5678;
      @(negedge clk);
      chk("wr_gnt", 64'(gnt), 64'h1);
      chk("wr_ram_we", 64'(ram_we), 64'h1);
      chk("wr_ram_be", 64'(ram_be), 64'hF);
      chk("wr_ram_wdata", 64'(ram_wdata), 64'h1234_5678);
      chk("wr_ram_addr", 64'(ram_addr), 64'h4);
      next_cycle();
      we = '0;
      @(negedge clk);
      chk("wr_rd_gnt", 64'(gnt), 64'h1);
      chk("wr_rvalid", 64'(rvalid), 64'h1);
      chk("wr_hold_unchanged", 64'(rd(0)), 64'h0);
      next_cycle();
      req = '0;
      @(negedge clk);
      chk("wr_rd_rvalid", 64'(rvalid), 64'h1);
      chk("wr_rd_rdata", 64'(rd(0)), 64'h1234_5678);
      chk("wr_other_hold", 64'(rd(1)), 64'hDEAD_BEEF);

      // Reset while port 3's response is pending.
      next_cycle();
      req = 4'b1000;
      @(negedge clk);
      chk("mr_gnt", 64'(gnt), 64'h8);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_rvalid_in_rst", 64'(rvalid), 64'h0);
      chk("mr_hold_cleared", 64'(rd(1)), 64'h0);
      next_cycle();
      chk("mr_rvalid_dropped", 64'(rvalid), 64'h0);
      rst_n = 1'b1; req = 4'b1010;
      @(negedge clk);
      chk("mr_first_gnt", 64'(gnt), 64'h2);
      next_cycle();
      req = '0;
      @(negedge clk);
      chk("mr_first_rvalid", 64'(rvalid), 64'h2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_arb_mux.md
RAM_ARB_MUX -- requirements
Module: ram_arb_mux

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2, number of requester ports (legal range 2..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 15, RAM word-address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, data width; byte-enable width BE_W = DATA_WIDTH/8.
REQ-004 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 The block SHALL have port port_req_i, input, NUM_PORTS, per-port access request.
REQ-007 The block SHALL have port port_addr_i, input, NUM_PORTS*ADDR_WIDTH, per-port address; port k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 The block SHALL have port port_we_i, input, NUM_PORTS, per-port write enable.
REQ-009 The block SHALL have port port_be_i, input, NUM_PORTS*BE_W, per-port byte enables.
REQ-010 The block SHALL have port port_wdata_i, input, NUM_PORTS*DATA_WIDTH, per-port write data.
REQ-011 The block SHALL have port port_gnt_o, output, NUM_PORTS, one-hot-or-zero grant.
REQ-012 The block SHALL have port port_rvalid_o, output, NUM_PORTS, per-port response valid.
REQ-013 The block SHALL have port port_rdata_o, output, NUM_PORTS*DATA_WIDTH, per-port held read data.
REQ-014 The block SHALL have outputs ram_en_o (1), ram_addr_o (ADDR_WIDTH), ram_we_o (1), ram_be_o (BE_W) and ram_wdata_o (DATA_WIDTH), plus input ram_rdata_i (DATA_WIDTH); the RAM has one-cycle read latency.

Function
REQ-015 port_gnt_o SHALL be combinational from port_req_i and the arbitration state; at most one bit SHALL be set, and it SHALL be set only where port_req_i is set.
REQ-016 A grant SHALL be issued in every cycle in which any port_req_i bit is high; no idle cycle SHALL occur between back-to-back grants.
REQ-017 ram_en_o SHALL equal |port_gnt_o; ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o SHALL be the granted port's slices, and SHALL be all-zero when there is no grant.
REQ-018 A registered response-owner index and valid flag SHALL capture the granted port; port_rvalid_o[k] SHALL pulse exactly one cycle after port k's grant, for both reads and writes.
REQ-019 On a read response cycle, ram_rdata_i SHALL be captured into port k's hold register; port_rdata_o slice k SHALL show ram_rdata_i in the rvalid cycle and the held value afterwards, until port k's next read response.
REQ-020 Write responses SHALL NOT modify port k's hold register.
REQ-021 A requester SHALL keep its request fields stable until granted; the block SHALL NOT buffer requests that are not granted.
REQ-022 Simultaneous requests on all ports SHALL be serviced at one grant per cycle, with order per REQ-026 or REQ-027.
REQ-023 A request and a response for the same port in the same cycle SHALL both be honoured (pipelined access).

Reset
REQ-024 While rst_n is low, port_rvalid_o, the response flag and all hold registers SHALL be 0, and the arbitration pointer SHALL be NUM_PORTS-1.
REQ-025 Assertion of rst_n mid-operation SHALL drop any pending rvalid without emitting it; the first grant after release SHALL follow REQ-026 or REQ-027 from the reset pointer.

Configuration
REQ-026 With RAM_ARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at (last_granted+1) mod NUM_PORTS, and the pointer updates on every grant.
REQ-027 Without RAM_ARB_RR_EN, arbitration SHALL be fixed priority with the lowest index winning; the pointer register SHALL be absent.

Verification
REQ-028 Reset/idle: rst_n=0 then released with no requests -> all gnt, rvalid and rdata 0; ram_en_o=0.
REQ-029 Single read: port1 reads addr 0x010 with RAM word 0xDEADBEEF -> gnt[1] in cycle 0, rvalid[1] in cycle 1, rdata[1]=0xDEADBEEF held until port1's next read.
REQ-030 Write then read: port0 writes 0x12345678 with be=0xF to 0x004, then reads 0x004 -> rvalid[0] on both transactions; read returns 0x12345678; port0's hold register is unchanged by the write.
REQ-031 Contention, RR enabled, NUM_PORTS=4, all ports requesting continuously -> grant order 0,1,2,3,0; each port's rvalid arrives one cycle after its own grant.
REQ-032 Contention, RR disabled, ports 0 and 2 requesting continuously -> port0 granted every cycle and port2 starves; when port0 drops its request, port2 is granted in the same cycle.
REQ-033 Mid-operation reset: port3 granted, rst_n pulled low before the next edge -> no rvalid[3]; after release, the first grant goes to the lowest requesting index.
